// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: pixel-tick divider, x/y raster counters,
// syncs, blanking and four colour patterns, all registered with zero skew to x/y.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4,
    parameter int COLOR_W    = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [1:0]                                         mode,
    output logic [COLOR_W-1:0]                                 r,
    output logic [COLOR_W-1:0]                                 g,
    output logic [COLOR_W-1:0]                                 b,
    output logic                                               hsync,
    output logic                                               vsync,
    output logic                                               blank,
    output logic                                               outclk,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]       x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]       y,
    output logic                                               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int XW1     = XW + 1;
    localparam int YW1     = YW + 1;
    localparam int DW      = $clog2(CLK_DIV);
    localparam int PW      = XW + 3;

    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF = DW'(CLK_DIV / 2 - 1);
    localparam logic [XW-1:0]  X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]  Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW1-1:0] H_VIS    = XW1'(H_ACTIVE);
    localparam logic [XW1-1:0] HS_START = XW1'(H_ACTIVE + H_FP);
    localparam logic [XW1-1:0] HS_END   = XW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW1-1:0] V_VIS    = YW1'(V_ACTIVE);
    localparam logic [YW1-1:0] VS_START = YW1'(V_ACTIVE + V_FP);
    localparam logic [YW1-1:0] VS_END   = YW1'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PW-1:0]  BAR_DEN  = PW'(H_ACTIVE);

    logic [DW-1:0]      div_reg;
    logic [XW-1:0]      x_reg, x_next;
    logic [YW-1:0]      y_reg, y_next;
    logic [1:0]         mode_reg, mode_sel;
    logic               hsync_reg, hsync_next;
    logic               vsync_reg, vsync_next;
    logic               blank_reg, blank_next;
    logic [COLOR_W-1:0] r_reg, r_next;
    logic [COLOR_W-1:0] g_reg, g_next;
    logic [COLOR_W-1:0] b_reg, b_next;
    logic               outclk_reg;
    logic               frame_start_reg;
    logic               tick;
    logic               frame_entry;
    logic [PW-1:0]      bar_prod;
    logic [2:0]         bar_idx;
    logic               checker_on;

    assign tick = (div_reg == DIV_LAST);

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (tick) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                y_next = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    assign frame_entry = tick && (x_next == '0) && (y_next == '0);
    // The first pixel of a frame already uses the mode being sampled on that edge.
    assign mode_sel    = frame_entry ? mode : mode_reg;

    // Decode everything from the position being entered so outputs land with x/y.
    assign hsync_next = !(({1'b0, x_next} >= HS_START) && ({1'b0, x_next} < HS_END));
    assign vsync_next = !(({1'b0, y_next} >= VS_START) && ({1'b0, y_next} < VS_END));
    assign blank_next = ({1'b0, x_next} < H_VIS) && ({1'b0, y_next} < V_VIS);

    assign bar_prod   = {x_next, 3'b000};
    assign bar_idx    = 3'(bar_prod / BAR_DEN);
    assign checker_on = x_next[CHECK_LOG2] ^ y_next[CHECK_LOG2];

    always_comb begin
        r_next = '0;
        g_next = '0;
        b_next = '0;
        if (blank_next) begin
            case (mode_sel)
                2'd0: begin
                    r_next = '1;
                    g_next = '1;
                    b_next = '1;
                end
                2'd1: begin
                    r_next = {COLOR_W{bar_idx[2]}};
                    g_next = {COLOR_W{bar_idx[1]}};
                    b_next = {COLOR_W{bar_idx[0]}};
                end
                2'd2: begin
                    r_next = {COLOR_W{checker_on}};
                    g_next = {COLOR_W{checker_on}};
                    b_next = {COLOR_W{checker_on}};
                end
                default: begin
                    r_next = COLOR_W'(x_next);
                    g_next = COLOR_W'(y_next);
                    b_next = COLOR_W'(x_next) + COLOR_W'(y_next);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg         <= '0;
            x_reg           <= X_LAST;
            y_reg           <= Y_LAST;
            mode_reg        <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            blank_reg       <= 1'b0;
            r_reg           <= '0;
            g_reg           <= '0;
            b_reg           <= '0;
            outclk_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_reg         <= tick ? '0 : div_reg + 1'b1;
            frame_start_reg <= frame_entry;
            if (frame_entry) begin
                mode_reg <= mode;
            end
            // outclk stays low after reset until the first tick starts a pixel period.
            if (tick) begin
                outclk_reg <= 1'b1;
            end else if (div_reg == DIV_HALF) begin
                outclk_reg <= 1'b0;
            end
            if (tick) begin
                x_reg     <= x_next;
                y_reg     <= y_next;
                hsync_reg <= hsync_next;
                vsync_reg <= vsync_next;
                blank_reg <= blank_next;
                r_reg     <= r_next;
                g_reg     <= g_next;
                b_reg     <= b_next;
            end
        end
    end

    assign x           = x_reg;
    assign y           = y_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign blank       = blank_reg;
    assign r           = r_reg;
    assign g           = g_reg;
    assign b           = b_reg;
    assign outclk      = outclk_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster: a clock-count based raster model
// checks every cycle, plus directed literal checks of the key positions.
module tb_vga_pattern_gen;
    localparam int H_ACTIVE = 24, H_FP = 4, H_SYNC = 6, H_BP = 6;
    localparam int V_ACTIVE = 8, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int CLK_DIV = 4, COLOR_W = 8, CHECK_LOG2 = 2;
    localparam int HT = 40, VT = 15, XW = 6, YW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [COLOR_W-1:0] r, g, b;
    logic hsync, vsync, blank, outclk, frame_start;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .COLOR_W(COLOR_W), .CHECK_LOG2(CHECK_LOG2)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .blank(blank), .outclk(outclk),
        .x(x), .y(y), .frame_start(frame_start)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int n;                       // rising edges since reset release
    logic [1:0] mode_seen;
    logic [1:0] frame_mode = 2'd0;
    int m_x, m_y, m_t, m_d, m_p;
    logic e_hs, e_vs, e_bl, e_oc, e_fs;
    logic [23:0] e_rgb;

    always @(posedge clk or negedge rst)
        if (!rst) n <= 0;
        else      n <= n + 1;

    always @(posedge clk) mode_seen <= mode;

    function automatic logic [23:0] pix(input int px, input int py, input logic [1:0] md);
        int idx;
        case (md)
            2'd0: return 24'hffffff;
            2'd1: begin
                idx = (px * 8) / H_ACTIVE;
                return {((idx & 4) != 0) ? 8'hff : 8'h00,
                        ((idx & 2) != 0) ? 8'hff : 8'h00,
                        ((idx & 1) != 0) ? 8'hff : 8'h00};
            end
            2'd2: return ((((px >> CHECK_LOG2) ^ (py >> CHECK_LOG2)) & 1) != 0) ? 24'hffffff : 24'h0;
            default: return {8'(px), 8'(py), 8'(px + py)};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) frame_mode = 2'd0;
        m_t = n / CLK_DIV;
        m_d = n % CLK_DIV;
        if (m_t == 0) begin
            m_x = HT - 1; m_y = VT - 1;
            e_hs = 1; e_vs = 1; e_bl = 0; e_oc = 0; e_fs = 0; e_rgb = 24'h0;
        end else begin
            m_p = (m_t - 1) % (HT * VT);
            m_x = m_p % HT;
            m_y = m_p / HT;
            e_fs = (m_d == 0) && (m_p == 0);
            if (e_fs) frame_mode = mode_seen;
            e_hs = !(m_x >= H_ACTIVE + H_FP && m_x < H_ACTIVE + H_FP + H_SYNC);
            e_vs = !(m_y >= V_ACTIVE + V_FP && m_y < V_ACTIVE + V_FP + V_SYNC);
            e_bl = (m_x < H_ACTIVE) && (m_y < V_ACTIVE);
            e_oc = (m_d < CLK_DIV / 2);
            e_rgb = e_bl ? pix(m_x, m_y, frame_mode) : 24'h0;
        end
        chk("m_x", 32'(x), 32'(m_x));
        chk("m_y", 32'(y), 32'(m_y));
        chk("m_hsync", 32'(hsync), 32'(e_hs));
        chk("m_vsync", 32'(vsync), 32'(e_vs));
        chk("m_blank", 32'(blank), 32'(e_bl));
        chk("m_outclk", 32'(outclk), 32'(e_oc));
        chk("m_frame_start", 32'(frame_start), 32'(e_fs));
        chk("m_rgb", {8'h0, r, g, b}, {8'h0, e_rgb});
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_model(input int wx, input int wy);
        bit hit = 0;
        for (int k = 0; k < 4000 && !hit; k++) begin
            @(negedge clk); #1;
            if (m_x == wx && m_y == wy) hit = 1;
        end
        chk($sformatf("reach_%0d_%0d", wx, wy), 32'(hit), 32'd1);
    endtask

    task automatic chk_rgb(input string name, input logic [23:0] want);
        chk(name, {8'h0, r, g, b}, {8'h0, want});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(x), 32'd39);
        chk({tag, "_y"}, 32'(y), 32'd14);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_blank"}, 32'(blank), 32'd0);
        chk({tag, "_outclk"}, 32'(outclk), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk_rgb({tag, "_rgb"}, 24'h0);
    endtask

    initial begin
        int cnt;
        bit got;
        repeat (3) @(negedge clk);
        #1 chk_reset_vals("rst");

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("fs_early", 32'(frame_start), 32'd0);
        chk("x_early", 32'(x), 32'd39);
        @(posedge clk);
        #1 chk("fs_first", 32'(frame_start), 32'd1);
        chk("x_first", 32'(x), 32'd0);
        chk("y_first", 32'(y), 32'd0);
        chk("blank_first", 32'(blank), 32'd1);
        chk("outclk_first", 32'(outclk), 32'd1);
        chk_rgb("white_first", 24'hffffff);

        // mode change mid-frame must wait for the next frame
        wait_model(5, 5);  chk_rgb("white_5_5", 24'hffffff);
        mode = 2'd3;
        wait_model(2, 6);  chk_rgb("still_white", 24'hffffff);
        wait_model(5, 3);  chk_rgb("grad_5_3", {8'd5, 8'd3, 8'd8});
        wait_model(24, 4); chk("blank_24", 32'(blank), 32'd0); chk_rgb("rgb_24", 24'h0);
        wait_model(27, 4); chk("hs_27", 32'(hsync), 32'd1);
        wait_model(28, 4); chk("hs_28", 32'(hsync), 32'd0);
        wait_model(33, 4); chk("hs_33", 32'(hsync), 32'd0);
        wait_model(34, 4); chk("hs_34", 32'(hsync), 32'd1);
        wait_model(0, 9);  chk("vs_9", 32'(vsync), 32'd1); chk("blank_y9", 32'(blank), 32'd0);
        wait_model(0, 10); chk("vs_10", 32'(vsync), 32'd0);
        wait_model(0, 11); chk("vs_11", 32'(vsync), 32'd0);
        wait_model(0, 12); chk("vs_12", 32'(vsync), 32'd1);
        mode = 2'd1;

        wait_model(0, 0);  chk("fs_bars", 32'(frame_start), 32'd1); chk_rgb("bar0", 24'h0);
        wait_model(3, 0);  chk_rgb("bar1", 24'h0000ff);
        wait_model(8, 0);  chk_rgb("bar2", 24'h00ff00);
        wait_model(23, 0); chk_rgb("bar7", 24'hffffff);
        wait_model(24, 0); chk_rgb("bar_blank", 24'h0);
        mode = 2'd2;

        got = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge clk); #1;
            if (frame_start) got = 1;
        end
        chk("fs_sync", 32'(got), 32'd1);
        cnt = 0; got = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge clk); #1;
            cnt++;
            if (frame_start) got = 1;
        end
        chk("fs_period", 32'(cnt), 32'd2400);

        wait_model(4, 0);  chk_rgb("chk_4_0", 24'hffffff);
        wait_model(0, 4);  chk_rgb("chk_0_4", 24'hffffff);
        wait_model(4, 4);  chk_rgb("chk_4_4", 24'h0);

        // asynchronous reset mid-frame
        wait_model(13, 6);
        rst = 1'b0;
        mode = 2'd0;
        #1 chk_reset_vals("midrst");
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("fs_re_early", 32'(frame_start), 32'd0);
        @(posedge clk);
        #1 chk("fs_re", 32'(frame_start), 32'd1);
        chk("x_re", 32'(x), 32'd0);
        chk("y_re", 32'(y), 32'd0);
        chk_rgb("white_re", 24'hffffff);

        repeat (400) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- CLK_DIV, 4, clk cycles per pixel; even, >=2
- COLOR_W, 8, bits per colour channel
- CHECK_LOG2, 5, checkerboard square size is 2^CHECK_LOG2 pixels
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock; all logic on rising edge
- rst, in, 1, asynchronous active-low reset
- mode, in, 2, pattern select
- r, g, b, out, COLOR_W each, pixel colour
- hsync, vsync, out, 1 each, active-low syncs
- blank, out, 1, active-low blanking (0 = outside visible area)
- outclk, out, 1, pixel clock to the DAC
- x, y, out, clog2(H_TOTAL), clog2(V_TOTAL), current pixel position
- frame_start, out, 1, one-clk pulse on the tick entering (0,0)
REQ-003 SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; all outputs SHALL be registered.

Function
REQ-004 A divider SHALL count 0..CLK_DIV-1 and wrap; the pixel tick SHALL be a one-clk internal strobe when the divider equals CLK_DIV-1.
REQ-005 outclk SHALL be 1 while the divider is in 0..CLK_DIV/2-1 after a tick, else 0 (50% duty, period CLK_DIV clks).
REQ-006 On each tick, x SHALL increment; x = H_TOTAL-1 SHALL wrap to 0 and advance y; y = V_TOTAL-1 with the x wrap SHALL wrap to 0.
REQ-007 hsync, vsync, blank, r, g, b SHALL update on the same edge as x/y and always describe the position currently on x/y (zero skew between them).
REQ-008 hsync SHALL be 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; vsync SHALL be 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
REQ-009 blank SHALL be 1 iff x < H_ACTIVE and y < V_ACTIVE; when blank = 0, r, g, b SHALL all be 0.
REQ-010 mode SHALL be sampled into an internal latch only on the tick entering (0,0), with frame_start asserted on that edge; mode changes mid-frame SHALL have no effect until the next frame.
REQ-011 Visible pixels by latched mode:
- 0: solid white, all channels all-ones
- 1: eight vertical bars, idx = (x*8)/H_ACTIVE; r = idx[2], g = idx[1], b = idx[0], each replicated to COLOR_W bits
- 2: checkerboard, white if x[CHECK_LOG2] XOR y[CHECK_LOG2], else black
- 3: gradient, r = x mod 2^COLOR_W, g = y mod 2^COLOR_W, b = (x+y) mod 2^COLOR_W
REQ-012 The bar index multiply SHALL be wide enough to hold (H_TOTAL-1)*8 without overflow.

Reset
REQ-013 While rst = 0, regardless of clk:
- divider = 0
- x = H_TOTAL-1, y = V_TOTAL-1
- hsync = 1, vsync = 1, blank = 0
- r = g = b = 0, outclk = 0, frame_start = 0
- mode latch = 0
REQ-014 After rst rises, the first tick SHALL occur on the CLK_DIV-th rising clk edge and SHALL move to (0,0) with frame_start = 1 and the mode input sampled.
REQ-015 Reset asserted mid-frame SHALL immediately force the REQ-013 values; after release the next frame SHALL restart per REQ-014 with no partial line.

Verification
REQ-016 Defaults, rst released -> frame_start on 4th clk edge; x,y = 0,0; blank = 1; frame_start period 1,680,000 clks (800x525x4).
REQ-017 Defaults, measure one line -> hsync low exactly for x = 656..751 (96 ticks); blank low for x = 640..799; outclk period 4 clks, high 2.
REQ-018 Defaults, measure one frame -> vsync low exactly for y = 490..491; blank low for all of y = 480..524.
REQ-019 mode = 1 -> x = 0..79 gives rgb = 0,0,0; x = 80..159 gives b = 255 only; x = 560..639 gives 255,255,255; x = 640 gives rgb = 0.
REQ-020 mode switched 0->3 at y = 100 -> rest of frame stays white; next frame pixel (5,3) gives r = 5, g = 3, b = 8.
REQ-021 rst pulsed low at x = 300, y = 200; CLK_DIV = 2, H_ACTIVE = 16, V_ACTIVE = 8 override -> REQ-013 values during reset; frame_start 2 clks after release; hsync/vsync positions rescale correctly.
